// File: rtl/instr_main_decoder.sv
// Main control decoder: 5-bit major opcode -> registered datapath control strobes.
// Optional MAIN_DEC_ILLEGAL_EN adds a registered Illegal flag for unassigned/unknown opcodes.
module instr_main_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Opcode,
    output logic       Jump,
    output logic       Test,
    output logic       ResultSrc,
    output logic       ALUsrc2_01,
    output logic       ALUSrc2_10,
    output logic       RegDst,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUOp,
    output logic       RegWrite,
    output logic       ALUSrc1,
    output logic       WirteSrc2_10,
    output logic       WriteSrc1_01,
    output logic       JarSrc
`ifdef MAIN_DEC_ILLEGAL_EN
    ,
    output logic       Illegal
`endif
);

    typedef struct packed {
        logic jump;
        logic test;
        logic result_src;
        logic alu_src2_imm_s;
        logic alu_src2_imm_z;
        logic reg_dst;
        logic mem_write;
        logic branch;
        logic alu_op;
        logic reg_write;
        logic alu_src1;
        logic write_src_upper;
        logic write_src_link;
        logic jar_src;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Unknown (X/Z) opcodes fall through to the default arm and decode as NOP.
    always_comb begin
        ctrl_d = '0;
        case (Opcode)
            5'b00000: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.alu_op    = 1'b1;
            end
            5'b00001: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.alu_src2_imm_s = 1'b1;
            end
            5'b00010: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.alu_src2_imm_z = 1'b1;
                ctrl_d.alu_op         = 1'b1;
            end
            5'b00011: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.alu_src2_imm_s = 1'b1;
                ctrl_d.result_src     = 1'b1;
            end
            5'b00100: begin
                ctrl_d.mem_write      = 1'b1;
                ctrl_d.alu_src2_imm_s = 1'b1;
            end
            5'b00101: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.test   = 1'b1;
            end
            5'b00110: begin
                ctrl_d.test = 1'b1;
            end
            5'b00111: begin
                ctrl_d.reg_write       = 1'b1;
                ctrl_d.write_src_upper = 1'b1;
            end
            5'b01000: begin
                ctrl_d.jump = 1'b1;
            end
            5'b01001: begin
                ctrl_d.jump           = 1'b1;
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.write_src_link = 1'b1;
            end
            5'b01010: begin
                ctrl_d.jump    = 1'b1;
                ctrl_d.jar_src = 1'b1;
            end
            5'b01011: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.alu_src1       = 1'b1;
                ctrl_d.alu_src2_imm_s = 1'b1;
            end
            5'b01100: begin
                ctrl_d.reg_write      = 1'b1;
                ctrl_d.alu_src2_imm_z = 1'b1;
                ctrl_d.alu_op         = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef MAIN_DEC_ILLEGAL_EN
    logic illegal_d;
    logic illegal_q;

    always_comb begin
        illegal_d = 1'b1;
        case (Opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b01100: illegal_d = 1'b0;
            default:  illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign Illegal = illegal_q;
`endif

    assign Jump         = ctrl_q.jump;
    assign Test         = ctrl_q.test;
    assign ResultSrc    = ctrl_q.result_src;
    assign ALUsrc2_01   = ctrl_q.alu_src2_imm_s;
    assign ALUSrc2_10   = ctrl_q.alu_src2_imm_z;
    assign RegDst       = ctrl_q.reg_dst;
    assign MemWrite     = ctrl_q.mem_write;
    assign Branch       = ctrl_q.branch;
    assign ALUOp        = ctrl_q.alu_op;
    assign RegWrite     = ctrl_q.reg_write;
    assign ALUSrc1      = ctrl_q.alu_src1;
    assign WirteSrc2_10 = ctrl_q.write_src_upper;
    assign WriteSrc1_01 = ctrl_q.write_src_link;
    assign JarSrc       = ctrl_q.jar_src;

endmodule

// File: tb/tb_instr_main_decoder.sv
// Self-checking bench for instr_main_decoder: per-output reference model, directed and random stimulus.
module tb_instr_main_decoder;

    localparam int B_ILL = 14, B_JUMP = 13, B_TEST = 12, B_RSRC = 11, B_IMMS = 10, B_IMMZ = 9,
                   B_RDST = 8, B_MEMW = 7, B_BR = 6, B_ALUOP = 5, B_RW = 4, B_SRC1 = 3,
                   B_UPPER = 2, B_LINK = 1, B_JAR = 0;
`ifdef MAIN_DEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] Opcode = 5'b00000;
    logic Jump, Test, ResultSrc, ALUsrc2_01, ALUSrc2_10, RegDst, MemWrite, Branch;
    logic ALUOp, RegWrite, ALUSrc1, WirteSrc2_10, WriteSrc1_01, JarSrc;
    logic ill_w;
    logic [14:0] dut_vec;
    logic [14:0] exp_vec = '0;
    bit   cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    instr_main_decoder dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode),
        .Jump(Jump), .Test(Test), .ResultSrc(ResultSrc), .ALUsrc2_01(ALUsrc2_01),
        .ALUSrc2_10(ALUSrc2_10), .RegDst(RegDst), .MemWrite(MemWrite), .Branch(Branch),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .WirteSrc2_10(WirteSrc2_10),
        .WriteSrc1_01(WriteSrc1_01), .JarSrc(JarSrc)
`ifdef MAIN_DEC_ILLEGAL_EN
        , .Illegal(ill_w)
`endif
    );
`ifndef MAIN_DEC_ILLEGAL_EN
    assign ill_w = 1'b0;
`endif

    assign dut_vec = {ill_w, Jump, Test, ResultSrc, ALUsrc2_01, ALUSrc2_10, RegDst, MemWrite,
                      Branch, ALUOp, RegWrite, ALUSrc1, WirteSrc2_10, WriteSrc1_01, JarSrc};

    always #5 clk = ~clk;

    // Each output is described by the set of opcodes that assert it.
    function automatic logic [14:0] model(input logic [4:0] op);
        logic [14:0] v;
        int o;
        v = '0;
        if ($isunknown(op)) begin
            v[B_ILL] = ILL_EN;
            return v;
        end
        o = int'(op);
        v[B_RW]    = o inside {0, 1, 2, 3, 7, 9, 11, 12};
        v[B_RDST]  = (o == 0);
        v[B_ALUOP] = o inside {0, 2, 12};
        v[B_IMMS]  = o inside {1, 3, 4, 11};
        v[B_IMMZ]  = o inside {2, 12};
        v[B_RSRC]  = (o == 3);
        v[B_MEMW]  = (o == 4);
        v[B_BR]    = (o == 5);
        v[B_TEST]  = o inside {5, 6};
        v[B_UPPER] = (o == 7);
        v[B_JUMP]  = o inside {8, 9, 10};
        v[B_LINK]  = (o == 9);
        v[B_JAR]   = (o == 10);
        v[B_SRC1]  = (o == 11);
        v[B_ILL]   = ILL_EN && (o >= 13);
        return v;
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_vec <= '0;
        else        exp_vec <= model(Opcode);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model", dut_vec, exp_vec);
            n_checks++;
            if (!(dut_vec[B_IMMS] && dut_vec[B_IMMZ]) && !(dut_vec[B_LINK] && dut_vec[B_UPPER]) &&
                !(dut_vec[B_MEMW] && dut_vec[B_RW]) && (!dut_vec[B_JAR] || dut_vec[B_JUMP]) &&
                !(dut_vec[B_TEST] && dut_vec[B_RW]))
                n_pass++;
            else
                $display("FAIL invariant: got %b at %0t", dut_vec, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] lit;

    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        chk("reset_hold", dut_vec, 15'd0);
        #2 rst_n = 1'b1;                        // mid-cycle async release
        #1 chk("release_no_edge", dut_vec, 15'd0);
        @(posedge clk);
        chk("pre_edge_held", dut_vec, 15'd0);
        #1;
        lit = '0; lit[B_RW] = 1; lit[B_RDST] = 1; lit[B_ALUOP] = 1;
        chk("rtype", dut_vec, lit);
        Opcode = 5'b00101;
        tick();
        lit = '0; lit[B_BR] = 1; lit[B_TEST] = 1;
        chk("beq", dut_vec, lit);
        Opcode = 5'b00011;
        tick();
        lit = '0; lit[B_RW] = 1; lit[B_IMMS] = 1; lit[B_RSRC] = 1;
        chk("lw", dut_vec, lit);

        for (int i = 0; i < 32; i++) begin
            Opcode = 5'(i);
            tick();
        end
        tick();
        lit = '0; lit[B_ILL] = ILL_EN;
        chk("op11111", dut_vec, lit);

        Opcode = 5'b01001;
        tick();
        lit = '0; lit[B_JUMP] = 1; lit[B_RW] = 1; lit[B_LINK] = 1;
        chk("jal", dut_vec, lit);
        #2 rst_n = 1'b0;
        #1 chk("jal_async_reset", dut_vec, 15'd0);
        tick();
        chk("jal_reset_held", dut_vec, 15'd0);
        rst_n = 1'b1;
        tick();
        chk("jal_after_release", dut_vec, lit);

        Opcode = 'x;
        tick();
        tick();
        chk("x_opcode", dut_vec, model(5'bxxxxx) | (ILL_EN ? 15'd0 : 15'd0));

        for (int i = 0; i < 400; i++) begin
            Opcode = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            tick();
        end
        tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_main_decoder.md
# instr_main_decoder

Main control decoder of the 16-bit single-issue datapath. Decodes the 5-bit major opcode (instruction bits [15:11]) into the datapath's control strobes and mux selects, and registers them so they are stable for the whole following cycle. Sits between instruction fetch/IR and the datapath; the ALU decoder consumes ALUOp together with the funct field.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Opcode  in  5 [15:11]  major opcode field of the current instruction.
- Jump  out  1  PC loads a jump target.
- Test  out  1  ALU performs compare (subtract), flags updated, no writeback.
- ResultSrc  out  1  writeback data from memory (1) or ALU (0).
- ALUsrc2_01  out  1  ALU operand 2 = sign-extended immediate (select 01).
- ALUSrc2_10  out  1  ALU operand 2 = zero-extended immediate (select 10).
- RegDst  out  1  destination register is Rd (1) or Rt (0).
- MemWrite  out  1  data-memory write enable.
- Branch  out  1  conditional branch on equal flag.
- ALUOp  out  1  ALU function from funct field (1) or fixed add (0).
- RegWrite  out  1  register-file write enable.
- ALUSrc1  out  1  ALU operand 1 = PC (1) or Rs (0).
- WirteSrc2_10  out  1  writeback = upper immediate (select 10).
- WriteSrc1_01  out  1  writeback = PC+2 link (select 01).
- JarSrc  out  1  jump target from register Rs (1) or immediate (0).
- Illegal  out  1  present only with MAIN_DEC_ILLEGAL_EN; unassigned opcode.

## Operation
- Asserted outputs per opcode; every unlisted output is 0:
- 00000 R-type ALU: RegWrite, RegDst, ALUOp.
- 00001 ADDI: RegWrite, ALUsrc2_01.
- 00010 logical-immediate: RegWrite, ALUSrc2_10, ALUOp.
- 00011 LW: RegWrite, ALUsrc2_01, ResultSrc.
- 00100 SW: MemWrite, ALUsrc2_01.
- 00101 BEQ: Branch, Test.
- 00110 CMP: Test.
- 00111 LUI: RegWrite, WirteSrc2_10.
- 01000 J: Jump.
- 01001 JAL: Jump, RegWrite, WriteSrc1_01.
- 01010 JR: Jump, JarSrc.
- 01011 ADDPC: RegWrite, ALUSrc1, ALUsrc2_01.
- 01100 shift-immediate: RegWrite, ALUSrc2_10, ALUOp.
- 01101-11111: unassigned, decode as NOP (all outputs 0).
- Invariants (must hold every cycle): never ALUsrc2_01 & ALUSrc2_10; never WriteSrc1_01 & WirteSrc2_10; MemWrite implies !RegWrite; JarSrc implies Jump; Test implies !RegWrite.
- Opcode containing X/Z decodes as NOP.

## Timing
- Combinational decode of Opcode, captured in output registers on rising clk: one-cycle latency, outputs change only after a clock edge.
- rst_n low: all outputs (including Illegal) go to 0 immediately, independent of clk; held 0 while low.
- rst_n release: first edge with rst_n high loads the decode of the Opcode present at that edge.
- Opcode changes every cycle are supported; each edge reflects only the Opcode sampled at that edge, no history.
- Reset asserted mid-stream discards the pending decode; no partial outputs.

## Configuration
- MAIN_DEC_ILLEGAL_EN defined: Illegal port exists; registered high for one cycle after any edge sampling an unassigned opcode (01101-11111) or X/Z opcode; control outputs still NOP; 0 in reset.
- Undefined: no Illegal port; unassigned opcodes silently decode to NOP; all other behaviour identical.

## Test plan
- Reset: rst_n=0 with Opcode=00000 and clk toggling -> all outputs 0; deassert asynchronously mid-cycle -> outputs stay 0 until next rising edge.
- Opcode=00000 at edge -> RegWrite=1, RegDst=1, ALUOp=1, all others 0 after that edge; previous values held before it.
- Opcode=00101 -> Branch=1, Test=1, all others 0; then 00011 next cycle -> RegWrite, ALUsrc2_01, ResultSrc only.
- Sweep all 32 opcodes back-to-back one per cycle -> each output vector matches the map one cycle later; invariants checked every cycle.
- Opcode=11111 -> all controls 0; Illegal=1 with MAIN_DEC_ILLEGAL_EN, port absent without.
- Assert rst_n=0 between edges while Opcode=01001 is decoded -> Jump/RegWrite/WriteSrc1_01 drop to 0 immediately.
